// File: rtl/tx_response_scheduler_if.sv
// Response-path bus between the RF/ALU producers, the scheduler and the UART TX path.
// master drives responses and the TX busy flag; slave is the scheduler.
interface tx_response_scheduler_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0]   RF_RdData;
   logic                    RF_RdData_VLD;
   logic [2*DATA_WIDTH-1:0] ALU_OUT;
   logic                    ALU_OUT_VLD;
   logic                    UART_TX_Busy;
   logic [DATA_WIDTH-1:0]   UART_TX_DATA;
   logic                    UART_TX_VLD;
   logic                    SCHED_BUSY;
   logic                    DROP_ERR;
   logic                    TO_ERR;

   modport master (
      output RF_RdData,
      output RF_RdData_VLD,
      output ALU_OUT,
      output ALU_OUT_VLD,
      output UART_TX_Busy,
      input  UART_TX_DATA,
      input  UART_TX_VLD,
      input  SCHED_BUSY,
      input  DROP_ERR,
      input  TO_ERR
   );

   modport slave (
      input  RF_RdData,
      input  RF_RdData_VLD,
      input  ALU_OUT,
      input  ALU_OUT_VLD,
      input  UART_TX_Busy,
      output UART_TX_DATA,
      output UART_TX_VLD,
      output SCHED_BUSY,
      output DROP_ERR,
      output TO_ERR
   );
endinterface

// File: rtl/tx_response_scheduler.sv
// Round-robin RF/ALU response scheduler serialising bytes into the UART TX path,
// paced by the TX busy flag, with drop and busy-rise timeout error pulses.
module tx_response_scheduler #(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT_W  = 16
) (
   input logic CLK,
   input logic RST,
   tx_response_scheduler_if.slave bus
);
   localparam int AW = 2 * DATA_WIDTH;
   localparam logic [TIMEOUT_W-1:0] TO_PRE =
      {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_HI,
      WAIT_LO
   } state_t;

   state_t                state;
   logic                  rf_v;
   logic [DATA_WIDTH-1:0] rf_d;
   logic                  alu_v;
   logic [AW-1:0]         alu_d;
   logic [AW-1:0]         tx_buf;
   logic [1:0]            byte_cnt;
   logic [TIMEOUT_W-1:0]  to_cnt;
   logic                  last_alu;

   logic grant_ok;
   logic gnt_rf;
   logic gnt_alu;
   logic rf_cap;
   logic alu_cap;
   logic rf_drop;
   logic alu_drop;
   logic to_hit;
   logic byte_done;

   assign grant_ok = (state == IDLE) && !bus.UART_TX_Busy;
   assign gnt_rf   = grant_ok && rf_v && (!alu_v || last_alu);
   assign gnt_alu  = grant_ok && alu_v && (!rf_v || !last_alu);

   // A slot being granted this cycle can accept a refill.
   assign rf_cap   = bus.RF_RdData_VLD && (!rf_v || gnt_rf);
   assign alu_cap  = bus.ALU_OUT_VLD && (!alu_v || gnt_alu);
   assign rf_drop  = bus.RF_RdData_VLD && !rf_cap;
   assign alu_drop = bus.ALU_OUT_VLD && !alu_cap;

   // Timeout completes the byte as if busy had pulsed.
   assign to_hit    = (state == WAIT_HI) && !bus.UART_TX_Busy &&
                      (to_cnt == TO_PRE);
   assign byte_done = to_hit ||
                      ((state == WAIT_LO) && !bus.UART_TX_Busy);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state            <= IDLE;
         rf_v             <= 1'b0;
         rf_d             <= '0;
         alu_v            <= 1'b0;
         alu_d            <= '0;
         tx_buf           <= '0;
         byte_cnt         <= 2'd0;
         to_cnt           <= '0;
         last_alu         <= 1'b1;
         bus.UART_TX_DATA <= '0;
         bus.UART_TX_VLD  <= 1'b0;
         bus.SCHED_BUSY   <= 1'b0;
         bus.DROP_ERR     <= 1'b0;
         bus.TO_ERR       <= 1'b0;
      end else begin
         bus.DROP_ERR    <= rf_drop || alu_drop;
         bus.TO_ERR      <= to_hit;
         bus.UART_TX_VLD <= 1'b0;

         if (rf_cap) begin
            rf_v <= 1'b1;
            rf_d <= bus.RF_RdData;
         end else if (gnt_rf) begin
            rf_v <= 1'b0;
         end

         if (alu_cap) begin
            alu_v <= 1'b1;
            alu_d <= bus.ALU_OUT;
         end else if (gnt_alu) begin
            alu_v <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (gnt_rf || gnt_alu) begin
                  state           <= SEND;
                  bus.UART_TX_VLD <= 1'b1;
                  bus.SCHED_BUSY  <= 1'b1;
                  last_alu        <= gnt_alu;
                  if (gnt_alu) begin
                     tx_buf           <= alu_d;
                     byte_cnt         <= 2'd2;
                     bus.UART_TX_DATA <= alu_d[DATA_WIDTH-1:0];
                  end else begin
                     tx_buf           <= {{DATA_WIDTH{1'b0}}, rf_d};
                     byte_cnt         <= 2'd1;
                     bus.UART_TX_DATA <= rf_d;
                  end
               end
            end
            SEND: begin
               state  <= WAIT_HI;
               to_cnt <= '0;
            end
            WAIT_HI: begin
               if (bus.UART_TX_Busy) begin
                  state <= WAIT_LO;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            WAIT_LO: begin
               state <= WAIT_LO;
            end
            default: state <= IDLE;
         endcase

         if (byte_done) begin
            if (byte_cnt == 2'd2) begin
               tx_buf           <= tx_buf >> DATA_WIDTH;
               byte_cnt         <= 2'd1;
               bus.UART_TX_DATA <= tx_buf[AW-1:DATA_WIDTH];
               bus.UART_TX_VLD  <= 1'b1;
               state            <= SEND;
            end else begin
               byte_cnt       <= 2'd0;
               bus.SCHED_BUSY <= 1'b0;
               state          <= IDLE;
            end
         end
      end
   end
endmodule
